// File: rtl/cam_vip_pkg.sv
// Shared definitions for the camera VIP: receiver states, error bit
// positions and the RGB565 -> RGB888 expansion used by both directions.
package cam_vip_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        VSYNC     = 3'd1,
        WAIT_HREF = 3'd2,
        ACTIVE    = 3'd3,
        DONE      = 3'd4
    } cam_rx_state_e;

    localparam int ERR_SHORT_LINE  = 0;
    localparam int ERR_SHORT_FRAME = 1;
    localparam int ERR_ODD_BYTE    = 2;

    // Zero-padded expansion: each channel is left-aligned in its byte.
    function automatic logic [23:0] rgb565_to_888(input logic [15:0] p);
        return {p[15:11], 3'b000, p[10:5], 2'b00, p[4:0], 3'b000};
    endfunction

endpackage

// File: rtl/cam_rx_edge.sv
// Registers the camera sync lines once and derives edge strobes by
// comparing the current sample against the previous one.
module cam_rx_edge (
    input  logic cam_pclk_o,
    input  logic s_rstn,
    input  logic vsync,
    input  logic href,
    output logic vsync_rise,
    output logic vsync_fall,
    output logic href_fall
);

    logic vsync_p1;
    logic href_p1;

    always_ff @(posedge cam_pclk_o or negedge s_rstn) begin
        if (!s_rstn) begin
            vsync_p1 <= 1'b0;
            href_p1  <= 1'b0;
        end else begin
            vsync_p1 <= vsync;
            href_p1  <= href;
        end
    end

    assign vsync_rise = vsync & ~vsync_p1;
    assign vsync_fall = ~vsync & vsync_p1;
    assign href_fall  = ~href & href_p1;

endmodule

// File: rtl/cam_rx_monitor.sv
// Receive-side camera VIP: reassembles RGB565 pixels from the DVP byte
// bus, tracks column/line position, checksums frames and flags errors.
module cam_rx_monitor
    import cam_vip_pkg::*;
#(
    parameter int HRES  = 640,
    parameter int VRES  = 480,
    parameter int CNT_W = 16
) (
    input  logic             cam_pclk_o,
    input  logic             s_rstn,
    input  logic             cam_vsync_o,
    input  logic             cam_href_o,
    input  logic [7:0]       cam_data_o,
    output logic             pix_valid_o,
    output logic [15:0]      pix_rgb565_o,
    output logic [23:0]      pix_rgb888_o,
    output logic [CNT_W-1:0] pix_col_o,
    output logic [CNT_W-1:0] pix_line_o,
    output logic             frame_done_o,
    output logic [CNT_W-1:0] frame_cnt_o,
    output logic [31:0]      frame_sum_o,
    output logic [2:0]       err_o,
    input  logic             err_clr_i
);

    if (HRES >= (1 << CNT_W) || VRES >= (1 << CNT_W)) begin : g_param_check
        $error("cam_rx_monitor: HRES and VRES must be below 2**CNT_W");
    end

    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] COL_LAST  = CNT_W'(HRES - 1);
    localparam logic [CNT_W-1:0] LINE_LAST = CNT_W'(VRES - 1);

    cam_rx_state_e    state;
    logic             phase;
    logic [7:0]       byte0;
    logic [CNT_W-1:0] col;
    logic [CNT_W-1:0] line;
    logic [31:0]      sum;
    logic [15:0]      pix_word;
    logic [2:0]       err_set;
    logic             vsync_rise;
    logic             vsync_fall;
    logic             href_fall;

    cam_rx_edge u_edge (
        .cam_pclk_o (cam_pclk_o),
        .s_rstn     (s_rstn),
        .vsync      (cam_vsync_o),
        .href       (cam_href_o),
        .vsync_rise (vsync_rise),
        .vsync_fall (vsync_fall),
        .href_fall  (href_fall)
    );

    assign pix_word = {byte0, cam_data_o};

    always_comb begin
        err_set = 3'b000;
        if (state == WAIT_HREF && vsync_rise) begin
            err_set[ERR_SHORT_FRAME] = 1'b1;
        end else if (state == ACTIVE) begin
            if (cam_vsync_o) begin
                err_set[ERR_SHORT_FRAME] = 1'b1;
            end else if (!cam_href_o && href_fall) begin
                err_set[ERR_ODD_BYTE]   = phase;
                err_set[ERR_SHORT_LINE] = (col != '0);
            end
        end
    end

    // A new error on the clear cycle survives the clear.
    always_ff @(posedge cam_pclk_o or negedge s_rstn) begin
        if (!s_rstn) begin
            err_o <= 3'b000;
        end else begin
            err_o <= (err_clr_i ? 3'b000 : err_o) | err_set;
        end
    end

    always_ff @(posedge cam_pclk_o or negedge s_rstn) begin
        if (!s_rstn) begin
            state        <= IDLE;
            phase        <= 1'b0;
            byte0        <= '0;
            col          <= '0;
            line         <= '0;
            sum          <= '0;
            pix_valid_o  <= 1'b0;
            pix_rgb565_o <= '0;
            pix_rgb888_o <= '0;
            pix_col_o    <= '0;
            pix_line_o   <= '0;
            frame_done_o <= 1'b0;
            frame_cnt_o  <= '0;
            frame_sum_o  <= '0;
        end else begin
            pix_valid_o  <= 1'b0;
            frame_done_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (vsync_rise) state <= VSYNC;
                end
                VSYNC: begin
                    col   <= '0;
                    line  <= '0;
                    phase <= 1'b0;
                    sum   <= '0;
                    if (vsync_fall) state <= WAIT_HREF;
                end
                WAIT_HREF: begin
                    if (vsync_rise) begin
                        state <= VSYNC;
                    end else if (cam_href_o) begin
                        byte0 <= cam_data_o;
                        phase <= 1'b1;
                        state <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (cam_vsync_o) begin
                        state <= VSYNC;
                    end else if (cam_href_o) begin
                        if (!phase) begin
                            byte0 <= cam_data_o;
                            phase <= 1'b1;
                        end else begin
                            phase        <= 1'b0;
                            pix_valid_o  <= 1'b1;
                            pix_rgb565_o <= pix_word;
                            pix_rgb888_o <= rgb565_to_888(pix_word);
                            pix_col_o    <= col;
                            pix_line_o   <= line;
                            sum          <= sum + {16'h0000, pix_word};
                            // Lines are delimited by pixel count, not by href.
                            if (col == COL_LAST) begin
                                col <= '0;
                                if (line == LINE_LAST) state <= DONE;
                                else                   line  <= line + CNT_ONE;
                            end else begin
                                col <= col + CNT_ONE;
                            end
                        end
                    end else if (href_fall) begin
                        phase <= 1'b0;
                        if (col != '0) begin
                            col  <= '0;
                            line <= line + CNT_ONE;
                        end
                        state <= WAIT_HREF;
                    end
                end
                DONE: begin
                    frame_done_o <= 1'b1;
                    frame_sum_o  <= sum;
                    frame_cnt_o  <= frame_cnt_o + CNT_ONE;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cam_rx_monitor.sv
// Directed bench for cam_rx_monitor on a 4x2 frame: pixel stream,
// coordinates, checksum, frame count, error flags and reset behaviour.
module tb_cam_rx_monitor;

    localparam int HRES  = 4;
    localparam int VRES  = 2;
    localparam int CNT_W = 16;

    logic             cam_pclk_o  = 1'b0;
    logic             s_rstn      = 1'b0;
    logic             cam_vsync_o = 1'b0;
    logic             cam_href_o  = 1'b0;
    logic [7:0]       cam_data_o  = 8'h00;
    logic             err_clr_i   = 1'b0;
    logic             pix_valid_o;
    logic [15:0]      pix_rgb565_o;
    logic [23:0]      pix_rgb888_o;
    logic [CNT_W-1:0] pix_col_o;
    logic [CNT_W-1:0] pix_line_o;
    logic             frame_done_o;
    logic [CNT_W-1:0] frame_cnt_o;
    logic [31:0]      frame_sum_o;
    logic [2:0]       err_o;

    cam_rx_monitor #(.HRES(HRES), .VRES(VRES), .CNT_W(CNT_W)) dut (
        .cam_pclk_o   (cam_pclk_o),
        .s_rstn       (s_rstn),
        .cam_vsync_o  (cam_vsync_o),
        .cam_href_o   (cam_href_o),
        .cam_data_o   (cam_data_o),
        .pix_valid_o  (pix_valid_o),
        .pix_rgb565_o (pix_rgb565_o),
        .pix_rgb888_o (pix_rgb888_o),
        .pix_col_o    (pix_col_o),
        .pix_line_o   (pix_line_o),
        .frame_done_o (frame_done_o),
        .frame_cnt_o  (frame_cnt_o),
        .frame_sum_o  (frame_sum_o),
        .err_o        (err_o),
        .err_clr_i    (err_clr_i)
    );

    always #5 cam_pclk_o = ~cam_pclk_o;

    int n_cmp  = 0;
    int n_mis  = 0;
    int fd_cnt = 0;
    int fd_ref = 0;

    logic [15:0]      got_rgb[$];
    logic [CNT_W-1:0] got_col[$];
    logic [CNT_W-1:0] got_line[$];
    logic [15:0]      exp_rgb[$];
    logic [CNT_W-1:0] exp_col[$];
    logic [CNT_W-1:0] exp_line[$];
    logic [23:0]      last_888 = 24'h0;

    always @(negedge cam_pclk_o) begin
        if (pix_valid_o) begin
            got_rgb.push_back(pix_rgb565_o);
            got_col.push_back(pix_col_o);
            got_line.push_back(pix_line_o);
            last_888 <= pix_rgb888_o;
        end
        if (frame_done_o) fd_cnt <= fd_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic h, input logic [7:0] d);
        @(negedge cam_pclk_o);
        cam_href_o = h;
        cam_data_o = d;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 8'h00);
    endtask

    task automatic vsync_pulse();
        @(negedge cam_pclk_o);
        cam_vsync_o = 1'b1;
        cam_href_o  = 1'b0;
        @(negedge cam_pclk_o);
        @(negedge cam_pclk_o);
        cam_vsync_o = 1'b0;
        idle(2);
    endtask

    task automatic pix(input logic [15:0] p, input int c, input int l);
        step(1'b1, p[15:8]);
        step(1'b1, p[7:0]);
        exp_rgb.push_back(p);
        exp_col.push_back(CNT_W'(c));
        exp_line.push_back(CNT_W'(l));
    endtask

    task automatic send_line(input int base, input int l, input int n);
        for (int i = 0; i < n; i++) pix(16'(base + i), i, l);
    endtask

    task automatic clear_queues();
        got_rgb.delete();  got_col.delete();  got_line.delete();
        exp_rgb.delete();  exp_col.delete();  exp_line.delete();
        fd_ref = fd_cnt;
    endtask

    task automatic check_stream(input string tag, input int n);
        chk({tag, "_npix"}, 32'(got_rgb.size()), 32'(n));
        for (int i = 0; i < n && i < got_rgb.size() && i < exp_rgb.size(); i++) begin
            chk($sformatf("%s_rgb%0d", tag, i), 32'(got_rgb[i]), 32'(exp_rgb[i]));
            chk($sformatf("%s_col%0d", tag, i), 32'(got_col[i]), 32'(exp_col[i]));
            chk($sformatf("%s_line%0d", tag, i), 32'(got_line[i]), 32'(exp_line[i]));
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_valid"}, 32'(pix_valid_o), 32'h0);
        chk({tag, "_rgb565"}, 32'(pix_rgb565_o), 32'h0);
        chk({tag, "_rgb888"}, 32'(pix_rgb888_o), 32'h0);
        chk({tag, "_col"}, 32'(pix_col_o), 32'h0);
        chk({tag, "_line"}, 32'(pix_line_o), 32'h0);
        chk({tag, "_done"}, 32'(frame_done_o), 32'h0);
        chk({tag, "_cnt"}, 32'(frame_cnt_o), 32'h0);
        chk({tag, "_sum"}, frame_sum_o, 32'h0);
        chk({tag, "_err"}, 32'(err_o), 32'h0);
    endtask

    task automatic check_frame(input string tag, input int dn, input int cnt,
                               input logic [31:0] fsum, input logic [2:0] err);
        chk({tag, "_done_pulses"}, 32'(fd_cnt - fd_ref), 32'(dn));
        chk({tag, "_frame_cnt"}, 32'(frame_cnt_o), 32'(cnt));
        chk({tag, "_frame_sum"}, frame_sum_o, fsum);
        chk({tag, "_err"}, 32'(err_o), 32'(err));
    endtask

    task automatic pulse_clear(input string tag);
        @(negedge cam_pclk_o);
        err_clr_i = 1'b1;
        @(negedge cam_pclk_o);
        chk({tag, "_err_after_clr"}, 32'(err_o), 32'h0);
        err_clr_i = 1'b0;
    endtask

    initial begin
        // Reset state
        @(negedge cam_pclk_o);
        @(negedge cam_pclk_o);
        check_zero("reset");
        s_rstn = 1'b1;

        // Continuous href, pixels 0..7
        clear_queues();
        vsync_pulse();
        send_line(0, 0, 4);
        send_line(4, 1, 4);
        idle(4);
        check_stream("t1", 8);
        check_frame("t1", 1, 1, 32'h1C, 3'b000);
        chk("t1_rgb888_last", 32'(last_888), 32'h000038);

        // href gaps between lines
        clear_queues();
        vsync_pulse();
        send_line(0, 0, 4);
        idle(5);
        send_line(4, 1, 4);
        idle(5);
        check_stream("t2", 8);
        check_frame("t2", 1, 2, 32'h1C, 3'b000);

        // Short line 0: three pixels only
        clear_queues();
        vsync_pulse();
        send_line(0, 0, 3);
        idle(2);
        chk("t3_err_short_line", 32'(err_o), 32'h1);
        send_line(4, 1, 4);
        idle(4);
        check_stream("t3", 7);
        check_frame("t3", 1, 3, 32'h19, 3'b001);
        pulse_clear("t3");

        // Odd byte count: href drops after byte0 of pixel 2 (also a short line)
        clear_queues();
        vsync_pulse();
        send_line(0, 0, 2);
        step(1'b1, 8'h00);
        idle(2);
        chk("t4_err_odd", 32'(err_o), 32'h5);
        pulse_clear("t4");
        send_line(4, 1, 4);
        idle(4);
        check_stream("t4", 6);
        check_frame("t4", 1, 4, 32'h17, 3'b000);

        // Truncated frame, then a full frame
        clear_queues();
        vsync_pulse();
        send_line(0, 0, 4);
        vsync_pulse();
        check_stream("t5a", 4);
        check_frame("t5a", 0, 4, 32'h17, 3'b010);
        clear_queues();
        send_line(0, 0, 4);
        send_line(4, 1, 4);
        idle(4);
        check_stream("t5b", 8);
        check_frame("t5b", 1, 5, 32'h1C, 3'b010);

        // Reset in the middle of line 1
        clear_queues();
        vsync_pulse();
        send_line(0, 0, 4);
        pix(16'h0004, 0, 1);
        @(negedge cam_pclk_o);
        #2 s_rstn = 1'b0;
        #1 check_zero("t6_rst");
        check_stream("t6a", 5);
        @(negedge cam_pclk_o);
        s_rstn = 1'b1;
        clear_queues();
        for (int i = 5; i < 8; i++) begin
            step(1'b1, 8'h00);
            step(1'b1, 8'(i));
        end
        idle(3);
        chk("t6_ignored_npix", 32'(got_rgb.size()), 32'h0);
        chk("t6_ignored_done", 32'(fd_cnt - fd_ref), 32'h0);
        clear_queues();
        vsync_pulse();
        send_line(0, 0, 4);
        send_line(4, 1, 4);
        idle(4);
        check_stream("t6b", 8);
        check_frame("t6b", 1, 1, 32'h1C, 3'b000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/cam_rx_monitor.md
Name: cam_rx_monitor

Overview:
- Receive-side camera VIP. Samples the parallel DVP-style camera bus (pclk, vsync, href, 8-bit data) driven by the camera transmitter VIP and reassembles RGB565 pixels with column/line coordinates.
- Checks frame geometry, accumulates a per-frame checksum and reports errors.
- Used in the testbench beside the camera-interface DUT, as a scoreboard reference and a standalone loopback checker.

Parameters:
- HRES, 640, pixels per line.
- VRES, 480, lines per frame.
- CNT_W, 16, width of the column/line/frame counters; must hold max(HRES, VRES).

Ports:
- cam_pclk_o  input  1  pixel clock; all logic on posedge.
- s_rstn  input  1  reset.
- cam_vsync_o  input  1  frame sync, active high.
- cam_href_o  input  1  line valid, active high.
- cam_data_o  input  8  pixel byte bus.
- pix_valid_o  output  1  one-cycle strobe: new pixel on the pix_* outputs.
- pix_rgb565_o  output  16  pixel as {R5,G6,B5}.
- pix_rgb888_o  output  24  {R5,3'b0,G6,2'b0,B5,3'b0}.
- pix_col_o  output  CNT_W  column of the current pixel.
- pix_line_o  output  CNT_W  line of the current pixel.
- frame_done_o  output  1  one-cycle strobe at end of frame.
- frame_cnt_o  output  CNT_W  completed frames, wraps.
- frame_sum_o  output  32  checksum of the last completed frame.
- err_o  output  3  sticky errors: [0] short line, [1] short frame, [2] odd byte count.
- err_clr_i  input  1  synchronous clear of err_o.

Behaviour:
- Reset and clock: reset s_rstn, asynchronous, active-low; clock cam_pclk_o.
- Reset values: every output and internal register is 0; FSM in IDLE.
- Sampling: vsync, href and data are sampled on posedge cam_pclk_o.
- Byte order: first byte = {R[4:0],G[5:3]}, second byte = {G[2:0],B[4:0]}; pix_rgb565_o = {byte0, byte1}.
- Latency: pix_valid_o and its data/coordinates are registered and appear 1 cycle after the edge that sampled byte1.
- FSM states:
  - IDLE: wait for vsync rising edge (sampled 0 then 1) -> VSYNC.
  - VSYNC: clear col, line, byte phase and running sum. On vsync falling edge -> WAIT_HREF.
  - WAIT_HREF: stay until href = 1 -> ACTIVE, capturing this byte as byte0.
  - ACTIVE: while href = 1, toggle the byte phase each cycle.
    - On each byte1: emit a pixel, sum += zero-extended rgb565 (mod 2^32), col++.
    - When col reaches HRES-1 on a byte1: col <- 0, line++. href may stay high across line boundaries; lines are delimited by the pixel count, not by href.
    - When line reaches VRES-1 at col HRES-1: go to DONE.
- href falling edge in ACTIVE:
  - byte phase = 1 (byte0 pending): set err[2]; drop the partial pixel.
  - col != 0: set err[0]; col <- 0, line++.
  - Then return to WAIT_HREF.
- DONE: for 1 cycle, frame_done_o = 1, frame_sum_o <- final sum, frame_cnt_o++. Then -> IDLE.
- vsync rising edge in WAIT_HREF/ACTIVE (frame truncated):
  - set err[1]; no frame_done_o, frame_sum_o unchanged;
  - -> VSYNC (restart capture).
- vsync = 1 while in ACTIVE with href = 1: treated as the truncation case above.
- Bytes with href = 1 in IDLE/VSYNC: ignored, no error.
- err_clr_i clears err_o in the same cycle. If an error event coincides with the clear, the event wins (bit set).
- Reset mid-frame: immediate return to IDLE. Capture resumes only at the next vsync rising edge; a partial frame is never reported.
- Counter widths: col/line are CNT_W wide. A parameter check (elaboration-time assertion) requires HRES < 2^CNT_W and VRES < 2^CNT_W.
- Behaviour is identical when href deasserts between lines, provided each line has exactly 2*HRES bytes.

Decomposition:
- Package cam_vip_pkg:
  - state enum cam_rx_state_e {IDLE, VSYNC, WAIT_HREF, ACTIVE, DONE};
  - err bit index constants ERR_SHORT_LINE = 0, ERR_SHORT_FRAME = 1, ERR_ODD_BYTE = 2;
  - function rgb565_to_888, shared with the transmitter VIP.
- One sub-module, cam_rx_edge: registers vsync/href and provides the rise/fall strobes.
- Pixel assembly, counters, checksum and FSM stay in the top module.

Test Plan:
- HRES = 4, VRES = 2; transmitter sends pixels 0x0000..0x0007 as RGB565, href continuous -> 8 pix_valid_o pulses. (col, line) sequence (0,0)..(3,0),(0,1)..(3,1). frame_done_o once, frame_sum_o = 0x1C, frame_cnt_o = 1, err_o = 0.
- Same frame but href drops for 5 cycles after each line -> identical pixel stream and checksum, err_o = 0.
- href drops after 3 pixels in line 0 -> err[0] = 1. Next pixel reports (0,1); frame completes after line 1; frame_sum_o reflects only the received pixels.
- href drops after byte0 of pixel 2 (odd count) -> err[2] = 1, partial pixel not emitted. err_clr_i pulse -> err_o = 0 the next cycle.
- vsync rises after line 0 only -> err[1] = 1, no frame_done_o, frame_cnt_o unchanged. The following complete frame is captured correctly.
- s_rstn asserted mid-line 1 -> all outputs 0 immediately. After release, mid-frame bytes are ignored until the next vsync; the next frame is reported with frame_cnt_o = 1.
